shift_sequencer_arm: RTL

SHIFT_SEQUENCER_ARM -- requirements
Module: shift_sequencer_arm

---
 rtl/shift_sequencer_arm_pkg.sv | 29 ++
 rtl/shift_sequencer_arm_barrel_shift.sv | 53 +++++
 rtl/shift_sequencer_arm.sv | 94 +++++++++
 3 files changed

// File: rtl/shift_sequencer_arm_pkg.sv
// Shared definitions for the multi-cycle ARM register-specified shift sequencer.
package shift_sequencer_arm_pkg;

    // Width of the single barrel shifter's amount input
    localparam int unsigned SHAMT_WIDTH = 5;

    // Largest amount consumed by one barrel pass
    localparam int unsigned MAX_CHUNK = 31;

    typedef enum logic [1:0] {
        OP_LSL = 2'd0,
        OP_LSR = 2'd1,
        OP_ASR = 2'd2,
        OP_ROR = 2'd3
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Amount for the next barrel pass, saturated at MAX_CHUNK (wide remainder is pre-clamped)
    function automatic logic [SHAMT_WIDTH-1:0] clamp_chunk(input logic saturate,
                                                           input logic [SHAMT_WIDTH-1:0] low);
        clamp_chunk = saturate ? SHAMT_WIDTH'(MAX_CHUNK) : low;
    endfunction

endpackage

// File: rtl/shift_sequencer_arm_barrel_shift.sv
// Combinational ARM barrel shifter with a 5-bit amount; amount 0 passes data and carry through.
module barrel_shift_arm
    import shift_sequencer_arm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic [SHAMT_WIDTH-1:0] amount,
    input  shift_op_e              op,
    input  logic                   carry_flag,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   carry_out
);

    logic [DATA_WIDTH:0]   lsl_ext;
    logic [DATA_WIDTH:0]   lsr_ext;
    logic [DATA_WIDTH:0]   asr_ext;
    logic [DATA_WIDTH-1:0] ror_val;

    // Extended shifts carry the last bit shifted out in the extra position
    always_comb begin
        lsl_ext = {1'b0, data} << amount;
        lsr_ext = {data, 1'b0} >> amount;
        asr_ext = $signed({data, 1'b0}) >>> amount;
        ror_val = (data >> amount) | (data << (DATA_WIDTH - 32'(amount)));

        result    = data;
        carry_out = carry_flag;
        case (op)
            OP_LSL: begin
                result    = lsl_ext[DATA_WIDTH-1:0];
                carry_out = lsl_ext[DATA_WIDTH];
            end
            OP_LSR: begin
                result    = lsr_ext[DATA_WIDTH:1];
                carry_out = lsr_ext[0];
            end
            OP_ASR: begin
                result    = asr_ext[DATA_WIDTH:1];
                carry_out = asr_ext[0];
            end
            default: begin
                result    = ror_val;
                carry_out = ror_val[DATA_WIDTH-1];
            end
        endcase

        if (amount == '0) begin
            carry_out = carry_flag;
        end
    end

endmodule

// File: rtl/shift_sequencer_arm.sv
// Iterates one 5-bit barrel shifter to implement ARM shifts by 0..255.
module shift_sequencer_arm
    import shift_sequencer_arm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned AMT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [AMT_WIDTH-1:0]  in_amount,
    input  logic [1:0]            in_op,
    input  logic                  in_carry,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_carry
);

    state_e                 state_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   carry_q;
    logic [AMT_WIDTH-1:0]   rem_q;
    shift_op_e              op_q;

    logic [SHAMT_WIDTH-1:0] chunk;
    logic [AMT_WIDTH-1:0]   rem_next;
    logic [DATA_WIDTH-1:0]  shift_out;
    logic                   shift_carry_out;

    // Next pass amount and the remainder it leaves behind
    always_comb begin
        chunk    = clamp_chunk(rem_q > AMT_WIDTH'(MAX_CHUNK), rem_q[SHAMT_WIDTH-1:0]);
        rem_next = rem_q - AMT_WIDTH'(chunk);
    end

    barrel_shift_arm #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_barrel (
        .data       (data_q),
        .amount     (chunk),
        .op         (op_q),
        .carry_flag (carry_q),
        .result     (shift_out),
        .carry_out  (shift_carry_out)
    );

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = data_q;
    assign out_carry = carry_q;

    // Sequencer: accept, iterate barrel passes, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            rem_q   <= '0;
            op_q    <= OP_LSL;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        carry_q <= in_carry;
                        rem_q   <= in_amount;
                        op_q    <= shift_op_e'(in_op);
                        state_q <= (in_amount == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    data_q  <= shift_out;
                    carry_q <= shift_carry_out;
                    rem_q   <= rem_next;
                    if (rem_next == '0) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
